// File: rtl/bsg_halfpod_sdr_reset_sequencer_pkg.sv
// bsg_halfpod_sdr_reset_sequencer_pkg: state encodings and sizing helper shared by the sequencer and its decoders
package bsg_halfpod_sdr_reset_sequencer_pkg;
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] DIS_OFF  = 4'd1;
    localparam logic [3:0] TOK_HI   = 4'd2;
    localparam logic [3:0] TOK_LO   = 4'd3;
    localparam logic [3:0] UP_OFF   = 4'd4;
    localparam logic [3:0] DOWN_OFF = 4'd5;
    localparam logic [3:0] DS_OFF   = 4'd6;
    localparam logic [3:0] CORE_OFF = 4'd7;
    localparam logic [3:0] RUN      = 4'd8;

    typedef logic [3:0] bsg_halfpod_sdr_rst_state_e;

    function automatic int safe_clog2(input int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/bsg_halfpod_sdr_reset_sequencer_if.sv
// bsg_halfpod_sdr_reset_sequencer_if: start/stop controls and reset/status nets of the sequencer
interface bsg_halfpod_sdr_reset_sequencer_if;
    logic       start_i;
    logic       stop_i;
    logic       sdr_disable_o;
    logic       sdr_token_reset_o;
    logic       sdr_uplink_reset_o;
    logic       sdr_downlink_reset_o;
    logic       sdr_downstream_reset_o;
    logic       core_reset_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] state_o;

    modport master(output start_i, stop_i,
                   input sdr_disable_o, sdr_token_reset_o, sdr_uplink_reset_o, sdr_downlink_reset_o,
                         sdr_downstream_reset_o, core_reset_o, busy_o, done_o, state_o);
    modport slave(input start_i, stop_i,
                  output sdr_disable_o, sdr_token_reset_o, sdr_uplink_reset_o, sdr_downlink_reset_o,
                         sdr_downstream_reset_o, core_reset_o, busy_o, done_o, state_o);
endinterface

// File: rtl/bsg_halfpod_sdr_reset_sequencer_counter.sv
// bsg_halfpod_sdr_reset_sequencer_counter: clear/up dwell counter, clear has priority
module bsg_halfpod_sdr_reset_sequencer_counter #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               async_reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);
    always_ff @(posedge clk_i or posedge async_reset_i)
        if (async_reset_i) count_o <= '0;
        else count_o <= clear_i ? '0 : count_o + width_p'(up_i);
endmodule

// File: rtl/bsg_halfpod_sdr_reset_sequencer.sv
// bsg_halfpod_sdr_reset_sequencer: walks the SDR link / core bring-up order with a fixed dwell per step
module bsg_halfpod_sdr_reset_sequencer
    import bsg_halfpod_sdr_reset_sequencer_pkg::*;
#(
    parameter int wait_cycles_p = 64
) (
    input logic                               clk_i,
    input logic                               async_reset_i,
    bsg_halfpod_sdr_reset_sequencer_if.slave  io
);
    localparam int cw = safe_clog2(wait_cycles_p);

    bsg_halfpod_sdr_rst_state_e state_r, state_n;
    logic [cw-1:0] count;
    logic timed, dwell_done;

    assign timed      = state_r != IDLE && state_r != RUN;
    assign dwell_done = count == cw'(wait_cycles_p - 1);
    assign io.state_o = state_r;

    // stop wins everywhere but IDLE; undefined encodings fall back to IDLE
    always_comb
        state_n = (io.stop_i && state_r != IDLE) ? IDLE
                : state_r == IDLE ? ((io.start_i && !io.stop_i) ? DIS_OFF : IDLE)
                : state_r == RUN  ? RUN
                : state_r >  RUN  ? IDLE
                : dwell_done      ? state_r + 4'd1
                : state_r;

    bsg_halfpod_sdr_reset_sequencer_counter #(.width_p(cw)) dwell (
        .clk_i        (clk_i),
        .async_reset_i(async_reset_i),
        .clear_i      (state_n != state_r),
        .up_i         (timed),
        .count_o      (count)
    );

    always_ff @(posedge clk_i or posedge async_reset_i)
        if (async_reset_i) begin
            state_r                   <= IDLE;
            io.sdr_disable_o          <= 1'b1;
            io.sdr_token_reset_o      <= 1'b0;
            io.sdr_uplink_reset_o     <= 1'b1;
            io.sdr_downlink_reset_o   <= 1'b1;
            io.sdr_downstream_reset_o <= 1'b1;
            io.core_reset_o           <= 1'b1;
            io.busy_o                 <= 1'b0;
            io.done_o                 <= 1'b0;
        end else begin
            state_r                   <= state_n;
            io.sdr_disable_o          <= state_n == IDLE;
            io.sdr_token_reset_o      <= state_n == TOK_HI;
            io.sdr_uplink_reset_o     <= state_n < UP_OFF;
            io.sdr_downlink_reset_o   <= state_n < DOWN_OFF;
            io.sdr_downstream_reset_o <= state_n < DS_OFF;
            io.core_reset_o           <= state_n < CORE_OFF;
            io.busy_o                 <= state_n != IDLE && state_n != RUN;
            io.done_o                 <= state_n == RUN;
        end
endmodule

// File: tb/tb_bsg_halfpod_sdr_reset_sequencer.sv
// tb_bsg_halfpod_sdr_reset_sequencer: directed checks of bring-up timing, abort, async reset and corners
module tb_bsg_halfpod_sdr_reset_sequencer;
    logic clk_i = 1'b0;
    logic async_reset_i;
    int checks = 0;
    int errors = 0;

    bsg_halfpod_sdr_reset_sequencer_if a();
    bsg_halfpod_sdr_reset_sequencer_if b();

    bsg_halfpod_sdr_reset_sequencer #(.wait_cycles_p(4)) dut4 (
        .clk_i(clk_i), .async_reset_i(async_reset_i), .io(a.slave));
    bsg_halfpod_sdr_reset_sequencer #(.wait_cycles_p(1)) dut1 (
        .clk_i(clk_i), .async_reset_i(async_reset_i), .io(b.slave));

    always #5 clk_i = ~clk_i;

    // {disable, token, up, down, ds, core, busy, done} per state 0..8
    logic [7:0] tbl [9] = '{8'b10111100, 8'b00111110, 8'b01111110, 8'b00111110, 8'b00011110,
                            8'b00001110, 8'b00000110, 8'b00000010, 8'b00000001};

    function automatic logic [7:0] outs_a();
        return {a.sdr_disable_o, a.sdr_token_reset_o, a.sdr_uplink_reset_o, a.sdr_downlink_reset_o,
                a.sdr_downstream_reset_o, a.core_reset_o, a.busy_o, a.done_o};
    endfunction

    function automatic logic [7:0] outs_b();
        return {b.sdr_disable_o, b.sdr_token_reset_o, b.sdr_uplink_reset_o, b.sdr_downlink_reset_o,
                b.sdr_downstream_reset_o, b.core_reset_o, b.busy_o, b.done_o};
    endfunction

    function automatic int exp_st(input int e, input int w);
        if (e < 1) return 0;
        if (e >= 1 + 7 * w) return 8;
        return 1 + (e - 1) / w;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        async_reset_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (outs_a() !== tbl[0]) begin errors++; $display("FAIL reset_outs4 got %b want %b", outs_a(), tbl[0]); end
        checks++;
        if (a.state_o !== 4'd0) begin errors++; $display("FAIL reset_state4 got %0d want 0", a.state_o); end
        checks++;
        if (outs_b() !== tbl[0]) begin errors++; $display("FAIL reset_outs1 got %b want %b", outs_b(), tbl[0]); end
        @(negedge clk_i);
        async_reset_i = 1'b0;
        tick();
        checks++;
        if (a.state_o !== 4'd0) begin errors++; $display("FAIL post_reset_idle got %0d want 0", a.state_o); end
    endtask

    task automatic test_full_bringup();
        int tok = 0;
        a.start_i = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e == 1) a.start_i = 1'b0;
            if (a.sdr_token_reset_o) tok++;
            checks++;
            if (a.state_o !== 4'(exp_st(e, 4))) begin
                errors++; $display("FAIL full_state e%0d got %0d want %0d", e, a.state_o, exp_st(e, 4));
            end
            checks++;
            if (outs_a() !== tbl[exp_st(e, 4)]) begin
                errors++; $display("FAIL full_outs e%0d got %b want %b", e, outs_a(), tbl[exp_st(e, 4)]);
            end
        end
        checks++;
        if (tok != 4) begin errors++; $display("FAIL token_width got %0d want 4", tok); end
        a.stop_i = 1'b1;
        tick();
        a.stop_i = 1'b0;
        checks++;
        if (outs_a() !== tbl[0] || a.state_o !== 4'd0) begin
            errors++; $display("FAIL stop_from_run got %b/%0d want %b/0", outs_a(), a.state_o, tbl[0]);
        end
    endtask

    task automatic test_abort();
        a.start_i = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 1) a.start_i = 1'b0;
        end
        checks++;
        if (a.state_o !== 4'd4) begin errors++; $display("FAIL abort_pre got %0d want 4", a.state_o); end
        a.stop_i = 1'b1;
        tick();
        a.stop_i = 1'b0;
        checks++;
        if (outs_a() !== tbl[0] || a.state_o !== 4'd0) begin
            errors++; $display("FAIL abort_idle got %b/%0d want %b/0", outs_a(), a.state_o, tbl[0]);
        end
        a.start_i = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 1) a.start_i = 1'b0;
            checks++;
            if (a.state_o !== 4'(exp_st(e, 4)) || outs_a() !== tbl[exp_st(e, 4)]) begin
                errors++;
                $display("FAIL replay e%0d got %0d/%b want %0d/%b", e, a.state_o, outs_a(), exp_st(e, 4), tbl[exp_st(e, 4)]);
            end
        end
        a.stop_i = 1'b1;
        tick();
        a.stop_i = 1'b0;
    endtask

    task automatic test_async_reset();
        a.start_i = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 1) a.start_i = 1'b0;
        end
        checks++;
        if (a.sdr_token_reset_o !== 1'b1) begin errors++; $display("FAIL async_pre_token got %b want 1", a.sdr_token_reset_o); end
        #3;
        async_reset_i = 1'b1;
        #1;
        checks++;
        if (outs_a() !== tbl[0] || a.state_o !== 4'd0) begin
            errors++; $display("FAIL async_mid got %b/%0d want %b/0", outs_a(), a.state_o, tbl[0]);
        end
        @(negedge clk_i);
        async_reset_i = 1'b0;
        tick();
        checks++;
        if (a.state_o !== 4'd0) begin errors++; $display("FAIL async_release got %0d want 0", a.state_o); end
    endtask

    task automatic test_corners();
        a.start_i = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 28) begin
                checks++;
                if (a.done_o !== 1'b0) begin errors++; $display("FAIL held_done_early got %b want 0", a.done_o); end
            end
            if (e == 29) begin
                checks++;
                if (a.done_o !== 1'b1) begin errors++; $display("FAIL held_done got %b want 1", a.done_o); end
            end
        end
        checks++;
        if (a.state_o !== 4'd8 || outs_a() !== tbl[8]) begin
            errors++; $display("FAIL start_in_run got %0d/%b want 8/%b", a.state_o, outs_a(), tbl[8]);
        end
        a.stop_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a.state_o !== 4'd0) begin errors++; $display("FAIL start_stop_idle c%0d got %0d want 0", i, a.state_o); end
        end
        a.start_i = 1'b0;
        a.stop_i = 1'b0;
        tick();
    endtask

    task automatic test_w1();
        int tok = 0;
        b.start_i = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 1) b.start_i = 1'b0;
            if (b.sdr_token_reset_o) tok++;
            checks++;
            if (b.state_o !== 4'(exp_st(e, 1)) || outs_b() !== tbl[exp_st(e, 1)]) begin
                errors++;
                $display("FAIL w1 e%0d got %0d/%b want %0d/%b", e, b.state_o, outs_b(), exp_st(e, 1), tbl[exp_st(e, 1)]);
            end
        end
        checks++;
        if (tok != 1) begin errors++; $display("FAIL w1_token_width got %0d want 1", tok); end
    endtask

    initial begin
        a.start_i = 1'b0;
        a.stop_i  = 1'b0;
        b.start_i = 1'b0;
        b.stop_i  = 1'b0;
        test_reset();
        test_full_bringup();
        test_abort();
        test_async_reset();
        test_corners();
        test_w1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
